// File: rtl/audio_sample_packer.sv
// Stereo PCM boxcar decimator that serialises each averaged pair as L then R words on a valid/ready stream.
// Define AUDIO_PACK_TAG_EN to tag each word with {channel, seq[2:0]} above the sample payload.
module audio_sample_packer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int DATA_SIZE    = 28,
    parameter int DECIM_LOG2   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_SIZE-1:0]    out_data,
    input  logic                    out_ready,
    output logic [15:0]             drop_count
);

    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SEND_L = 2'd1,
        SEND_R = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic signed [ACC_W-1:0]  r_accL;
    logic signed [ACC_W-1:0]  r_accR;
    logic [CNT_W-1:0]         r_cnt;
    logic [SAMPLE_WIDTH-1:0]  r_holdL;
    logic [SAMPLE_WIDTH-1:0]  r_holdR;
    logic [2:0]               r_seq;
    logic [15:0]              r_dropCount;

    logic signed [ACC_W-1:0]  w_sumL;
    logic signed [ACC_W-1:0]  w_sumR;
    logic [SAMPLE_WIDTH-1:0]  w_avgL;
    logic [SAMPLE_WIDTH-1:0]  w_avgR;
    logic                     w_xfer;
    logic                     w_last;
    logic [SAMPLE_WIDTH-1:0]  w_payload;
    logic [DATA_SIZE-1:0]     w_packed;

    // Sums include the current sample so the final transfer's average is complete in the same cycle.
    assign w_sumL = r_accL + ACC_W'($signed(in_left));
    assign w_sumR = r_accR + ACC_W'($signed(in_right));
    assign w_avgL = SAMPLE_WIDTH'(w_sumL >>> DECIM_LOG2);
    assign w_avgR = SAMPLE_WIDTH'(w_sumR >>> DECIM_LOG2);

    assign w_xfer = in_valid && in_ready;
    assign w_last = w_xfer && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_payload   = '0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_nextState = SEND_L;
                end
            end
            SEND_L: begin
                out_valid = 1'b1;
                w_payload = r_holdL;
                if (out_ready) begin
                    w_nextState = SEND_R;
                end
            end
            SEND_R: begin
                out_valid = 1'b1;
                w_payload = r_holdR;
                if (out_ready) begin
                    w_nextState = ACCUM;
                end
            end
            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

`ifdef AUDIO_PACK_TAG_EN
    assign w_packed = {(r_state == SEND_R), r_seq, (DATA_SIZE-4)'($signed(w_payload))};
`else
    assign w_packed = DATA_SIZE'($signed(w_payload));
`endif

    assign out_data   = out_valid ? w_packed : '0;
    assign drop_count = r_dropCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accL  <= '0;
            r_accR  <= '0;
            r_cnt   <= '0;
            r_holdL <= '0;
            r_holdR <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_accL  <= '0;
                r_accR  <= '0;
                r_cnt   <= '0;
                r_holdL <= w_avgL;
                r_holdR <= w_avgR;
            end else begin
                r_accL <= w_sumL;
                r_accR <= w_sumR;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    // seq advances once per completed pair, whether or not it is carried in the output words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq <= 3'd0;
        end else if (r_state == SEND_R && out_ready) begin
            r_seq <= r_seq + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dropCount <= 16'd0;
        end else if (in_valid && !in_ready && r_dropCount != 16'hFFFF) begin
            r_dropCount <= r_dropCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_audio_sample_packer.sv
// Directed bench for audio_sample_packer at default parameters (decimate by 4).
// Expected words follow AUDIO_PACK_TAG_EN when it is defined for the whole compile.
module tb_audio_sample_packer;

`ifdef AUDIO_PACK_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [23:0] in_left;
    logic [23:0] in_right;
    logic        in_ready;
    logic        out_valid;
    logic [27:0] out_data;
    logic        out_ready;
    logic [15:0] drop_count;

    int checkCount = 0;
    int errCount   = 0;

    audio_sample_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference packing of one output word.
    function automatic logic [27:0] pk(input logic ch, input logic [2:0] sq, input logic [23:0] s);
        if (TAG) return {ch, sq, s};
        return {{4{s[23]}}, s};
    endfunction

    task automatic doReset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pushPair(input logic [23:0] l, input logic [23:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic getWord(output logic [27:0] data, output bit ok);
        ok   = 1'b0;
        data = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                data = out_data;
                ok   = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checkCount++;
        if (out_valid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checkCount++;
        if (in_ready !== 1'b1) begin errCount++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checkCount++;
        if (out_data !== 28'h0) begin errCount++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checkCount++;
        if (drop_count !== 16'h0) begin errCount++; $display("[TB] FAIL reset_drop_count: got %h expected 0", drop_count); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_average();
        logic [27:0] expL;
        logic [27:0] expR;
        expL = 28'h000000A;
        expR = TAG ? 28'h8FFFFFC : 28'hFFFFFFC;
        doReset();
        out_ready = 1'b1;
        pushPair(24'd4,  24'hFFFFFC);
        pushPair(24'd8,  24'hFFFFFC);
        pushPair(24'd12, 24'hFFFFFC);
        checkCount++;
        if (out_valid !== 1'b0) begin errCount++; $display("[TB] FAIL avg_early_valid: got %b expected 0", out_valid); end
        pushPair(24'd16, 24'hFFFFFC);
        checkCount++;
        if (out_valid !== 1'b1) begin errCount++; $display("[TB] FAIL avg_latency_valid: got %b expected 1", out_valid); end
        checkCount++;
        if (out_data !== expL) begin errCount++; $display("[TB] FAIL avg_left_word: got %h expected %h", out_data, expL); end
        @(posedge clk); #1;
        checkCount++;
        if (out_valid !== 1'b1 || out_data !== expR) begin
            errCount++; $display("[TB] FAIL avg_right_word: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, expR);
        end
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errCount++; $display("[TB] FAIL avg_back_to_accum: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_floor();
        logic [27:0] w;
        bit ok;
        doReset();
        pushPair(24'hFFFFFF, 24'd0);
        pushPair(24'd0, 24'd0);
        pushPair(24'd0, 24'd0);
        pushPair(24'd0, 24'd0);
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== (TAG ? 28'h0FFFFFF : 28'hFFFFFFF)) begin
            errCount++; $display("[TB] FAIL floor_left: got %h (ok=%0b) expected %h", w, ok, TAG ? 28'h0FFFFFF : 28'hFFFFFFF);
        end
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== (TAG ? 28'h8000000 : 28'h0000000)) begin
            errCount++; $display("[TB] FAIL floor_right: got %h (ok=%0b) expected %h", w, ok, TAG ? 28'h8000000 : 28'h0000000);
        end
    endtask

    task automatic test_backpressure();
        logic [27:0] w;
        bit ok;
        doReset();
        pushPair(24'd100, 24'hFFFFF6);
        pushPair(24'd200, 24'hFFFFEC);
        pushPair(24'd300, 24'hFFFFE2);
        pushPair(24'd400, 24'hFFFFD8);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_left  = 24'h7FFFFF;
            in_right = 24'h7FFFFF;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checkCount++;
            if (out_valid !== 1'b1 || out_data !== pk(1'b0, 3'd0, 24'h0000FA)) begin
                errCount++; $display("[TB] FAIL bp_hold_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, pk(1'b0, 3'd0, 24'h0000FA));
            end
        end
        checkCount++;
        if (drop_count !== 16'd3) begin errCount++; $display("[TB] FAIL bp_drop_count: got %0d expected 3", drop_count); end
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b0, 3'd0, 24'h0000FA)) begin errCount++; $display("[TB] FAIL bp_left: got %h expected %h", w, pk(1'b0, 3'd0, 24'h0000FA)); end
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b1, 3'd0, 24'hFFFFE7)) begin errCount++; $display("[TB] FAIL bp_right: got %h expected %h", w, pk(1'b1, 3'd0, 24'hFFFFE7)); end
        pushPair(24'd1, 24'd0);
        pushPair(24'd2, 24'd0);
        pushPair(24'd3, 24'd0);
        pushPair(24'd4, 24'd0);
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b0, 3'd1, 24'd2)) begin errCount++; $display("[TB] FAIL bp_next_left: got %h expected %h", w, pk(1'b0, 3'd1, 24'd2)); end
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b1, 3'd1, 24'd0)) begin errCount++; $display("[TB] FAIL bp_next_right: got %h expected %h", w, pk(1'b1, 3'd1, 24'd0)); end
    endtask

    task automatic test_seq_wrap();
        logic [27:0] w;
        logic [23:0] lv;
        logic [23:0] rv;
        logic [2:0]  sq;
        bit ok;
        doReset();
        for (int k = 1; k <= 9; k++) begin
            lv = 24'(k);
            rv = 24'd0 - lv;
            sq = 3'(k - 1);
            repeat (4) pushPair(lv, rv);
            getWord(w, ok);
            checkCount++;
            if (!ok || w !== pk(1'b0, sq, lv)) begin errCount++; $display("[TB] FAIL seq_left_%0d: got %h expected %h", k, w, pk(1'b0, sq, lv)); end
            getWord(w, ok);
            checkCount++;
            if (!ok || w !== pk(1'b1, sq, rv)) begin errCount++; $display("[TB] FAIL seq_right_%0d: got %h expected %h", k, w, pk(1'b1, sq, rv)); end
        end
    endtask

    task automatic test_drop_saturation();
        doReset();
        repeat (4) pushPair(24'd0, 24'd0);
        in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checkCount++;
        if (drop_count !== 16'hFFFE) begin errCount++; $display("[TB] FAIL sat_below: got %h expected fffe", drop_count); end
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkCount++;
        if (drop_count !== 16'hFFFF) begin errCount++; $display("[TB] FAIL sat_hold: got %h expected ffff", drop_count); end
    endtask

    task automatic test_reset_mid_send();
        logic [27:0] w;
        bit ok;
        doReset();
        repeat (4) pushPair(24'd5, 24'd6);
        getWord(w, ok);
        getWord(w, ok);
        repeat (4) pushPair(24'd5, 24'd6);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        getWord(w, ok);
        checkCount++;
        if (!ok || out_valid !== 1'b1 || w !== pk(1'b0, 3'd1, 24'd5)) begin
            errCount++; $display("[TB] FAIL mid_pre_left: got %h valid=%b expected %h valid=1", w, out_valid, pk(1'b0, 3'd1, 24'd5));
        end
        #2;
        reset = 1'b1;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errCount++; $display("[TB] FAIL mid_reset_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        checkCount++;
        if (drop_count !== 16'd0) begin errCount++; $display("[TB] FAIL mid_reset_drop: got %0d expected 0", drop_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        repeat (4) pushPair(24'd8, 24'd0);
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b0, 3'd0, 24'd8)) begin errCount++; $display("[TB] FAIL mid_after_left: got %h expected %h", w, pk(1'b0, 3'd0, 24'd8)); end
        getWord(w, ok);
        checkCount++;
        if (!ok || w !== pk(1'b1, 3'd0, 24'd0)) begin errCount++; $display("[TB] FAIL mid_after_right: got %h expected %h", w, pk(1'b1, 3'd0, 24'd0)); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        out_ready = 1'b0;
        $display("[TB] starting audio_sample_packer bench, tag=%0b", TAG);
        test_reset();
        test_average();
        test_floor();
        test_backpressure();
        test_seq_wrap();
        test_drop_saturation();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
